pe_dot_scheduler: RTL and testbench

- Round-robin scheduler that shares one dot-product MAC between N_REQ requesters in the ICA datapath. Each requester needs a VLEN-element signed dot product.
- The block grants one requester at a time and drives the element index. It accumulates one product per cycle from the granted requester's data and returns a 2*DW-bit result tagged with the requester ID.
- It replaces the free-running per-PE accumulator with a sequenced, restartable, shared one.

---
 rtl/pe_dot_scheduler.sv | 154 +++++++++++++++
 tb/tb_pe_dot_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_scheduler.sv
// Round-robin scheduler that time-shares one signed dot-product MAC between
// N_REQ requesters, sequencing element indices and tagging each result with its owner.
module pe_dot_scheduler #(
  parameter int N_REQ = 4,
  parameter int VLEN  = 64,
  parameter int DW    = 32,
  parameter int IW    = $clog2(N_REQ),
  parameter int AW    = $clog2(VLEN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [DW-1:0]     a_data_i,
  input  logic [DW-1:0]     b_data_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [AW-1:0]     elem_idx_o,
  output logic              busy_o,
  output logic              res_valid_o,
  output logic [2*DW-1:0]   res_data_o,
  output logic [IW-1:0]     res_id_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [AW-1:0]       elem_idx_q, elem_idx_d;
  logic [2*DW-1:0]     acc_q, acc_d;
  logic [IW-1:0]       cur_id_q, cur_id_d;
  logic [IW-1:0]       last_gnt_q, last_gnt_d;
  logic [2*DW-1:0]     res_data_q, res_data_d;
  logic [IW-1:0]       res_id_q, res_id_d;

  logic [IW-1:0]       winner;
  logic [IW-1:0]       cand;
  logic                found;
  logic                abort;
  logic                last_elem;
  logic [2*DW-1:0]     a_ext, b_ext, prod, acc_sum;

  // Search starts just after the last served requester; offset N_REQ wraps to last_gnt itself.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last_gnt_q + IW'(i);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Unsigned multiply of sign-extended operands gives the signed product modulo 2^(2*DW).
  always_comb begin
    a_ext     = {{DW{a_data_i[DW-1]}}, a_data_i};
    b_ext     = {{DW{b_data_i[DW-1]}}, b_data_i};
    prod      = a_ext * b_ext;
    acc_sum   = acc_q + prod;
    abort     = !req_i[cur_id_q];
    last_elem = (elem_idx_q == AW'(VLEN - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == RUN) || (state_q == DONE);
    res_valid_o = (state_q == DONE);
  end

  always_comb begin
    gnt_d      = gnt_q;
    elem_idx_d = elem_idx_q;
    acc_d      = acc_q;
    cur_id_d   = cur_id_q;
    last_gnt_d = last_gnt_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = N_REQ'(1) << winner;
          cur_id_d   = winner;
          elem_idx_d = '0;
          acc_d      = '0;
        end
      end
      RUN: begin
        if (abort) begin
          gnt_d      = '0;
          elem_idx_d = '0;
          last_gnt_d = cur_id_q;
        end else begin
          acc_d = acc_sum;
          if (last_elem) begin
            gnt_d      = '0;
            res_data_d = acc_sum;
            res_id_d   = cur_id_q;
          end else begin
            elem_idx_d = elem_idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        last_gnt_d = cur_id_q;
        elem_idx_d = '0;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q      <= '0;
      elem_idx_q <= '0;
      acc_q      <= '0;
      cur_id_q   <= '0;
      last_gnt_q <= IW'(N_REQ - 1);
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      gnt_q      <= gnt_d;
      elem_idx_q <= elem_idx_d;
      acc_q      <= acc_d;
      cur_id_q   <= cur_id_d;
      last_gnt_q <= last_gnt_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign elem_idx_o = elem_idx_q;
  assign res_data_o = res_data_q;
  assign res_id_o   = res_id_q;

endmodule

// File: tb/tb_pe_dot_scheduler.sv
// Scenario-driven bench for pe_dot_scheduler; expected results come from a
// per-requester vector store and a plain-arithmetic dot product / round-robin model.
module tb_pe_dot_scheduler;

  localparam int N  = 4;
  localparam int V  = 64;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [DW-1:0] aData;
  logic [DW-1:0] bData;
  logic [N-1:0]  gnt;
  logic [5:0]    elemIdx;
  logic          busy;
  logic          resValid;
  logic [63:0]   resData;
  logic [1:0]    resId;

  logic signed [DW-1:0] aMem [0:N-1][0:V-1];
  logic signed [DW-1:0] bMem [0:N-1][0:V-1];

  int passCount  = 0;
  int checkCount = 0;
  int lastModel  = N - 1;

  pe_dot_scheduler #(.N_REQ(N), .VLEN(V), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .a_data_i(aData), .b_data_i(bData),
    .gnt_o(gnt), .elem_idx_o(elemIdx), .busy_o(busy), .res_valid_o(resValid),
    .res_data_o(resData), .res_id_o(resId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream operand mux: the granted requester presents its element at elemIdx.
  always_comb begin
    aData = '0;
    bData = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        aData = aMem[i][elemIdx];
        bData = bMem[i][elemIdx];
      end
    end
  end

  function automatic logic [63:0] dotRef(input int id);
    longint s = 0;
    for (int e = 0; e < V; e++) s += longint'(aMem[id][e]) * longint'(bMem[id][e]);
    return s;
  endfunction

  function automatic int rrPick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic fillConst(input int id, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    for (int e = 0; e < V; e++) begin
      aMem[id][e] = a;
      bMem[id][e] = b;
    end
  endtask

  task automatic fillRandom(input int id);
    for (int e = 0; e < V; e++) begin
      aMem[id][e] = $urandom;
      bMem[id][e] = $urandom;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    lastModel = N - 1;
  endtask

  task automatic waitGrant(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (gnt != '0) break;
    end
  endtask

  task automatic waitResult(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (resValid) break;
    end
  endtask

  task automatic waitIdx(input int target, output int n);
    n = 0;
    while (n < 200 && elemIdx != 6'(target)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    checkCount++; if (gnt !== '0) $display("[TB] FAIL reset_gnt: got %b expected 0", gnt); else passCount++;
    checkCount++; if (elemIdx !== '0) $display("[TB] FAIL reset_idx: got %0d expected 0", elemIdx); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (resValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", resValid); else passCount++;
    checkCount++; if (resData !== '0) $display("[TB] FAIL reset_data: got %h expected 0", resData); else passCount++;
    checkCount++; if (resId !== '0) $display("[TB] FAIL reset_id: got %0d expected 0", resId); else passCount++;
    rst = 1'b0;
    lastModel = N - 1;
  endtask

  task automatic test_single_job();
    int n;
    for (int e = 0; e < V; e++) begin
      aMem[0][e] = e;
      bMem[0][e] = 1;
    end
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    checkCount++; if (gnt !== 4'b0001) $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passCount++;
    waitResult(n);
    checkCount++; if (n != V) $display("[TB] FAIL single_latency: got %0d expected %0d", n, V); else passCount++;
    checkCount++; if (resData !== 64'd2016) $display("[TB] FAIL single_data: got %0d expected 2016", resData); else passCount++;
    checkCount++; if (resId !== 2'd0) $display("[TB] FAIL single_id: got %0d expected 0", resId); else passCount++;
    req = '0;
    @(negedge clk);
    checkCount++; if (resValid !== 1'b0) $display("[TB] FAIL single_strobe_len: got %b expected 0", resValid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (resData !== 64'd2016) $display("[TB] FAIL single_hold: got %0d expected 2016", resData); else passCount++;
  endtask

  task automatic test_round_robin();
    int n;
    int exp;
    doReset();
    for (int i = 0; i < N; i++) fillConst(i, i + 1, 1);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      waitGrant(n);
      exp = rrPick(4'b1111, lastModel);
      checkCount++; if (n != 1) $display("[TB] FAIL rr_gap job%0d: got %0d expected 1", j, n); else passCount++;
      checkCount++; if (gnt !== 4'(1 << exp)) $display("[TB] FAIL rr_gnt job%0d: got %b expected id %0d", j, gnt, exp); else passCount++;
      waitResult(n);
      checkCount++; if (resData !== dotRef(exp)) $display("[TB] FAIL rr_data job%0d: got %0d expected %0d", j, resData, dotRef(exp)); else passCount++;
      checkCount++; if (resId !== 2'(exp)) $display("[TB] FAIL rr_id job%0d: got %0d expected %0d", j, resId, exp); else passCount++;
      lastModel = exp;
      if (j == 4) begin
        req = '0;
        @(negedge clk);
      end else begin
        req[exp] = 1'b0;
        @(negedge clk);
        req[exp] = 1'b1;
      end
    end
  endtask

  task automatic test_sign_wrap();
    int n;
    doReset();
    fillConst(1, -1, 32'sh7FFFFFFF);
    req = 4'b0010;
    waitGrant(n);
    checkCount++; if (gnt !== 4'b0010) $display("[TB] FAIL sign_gnt: got %b expected 0010", gnt); else passCount++;
    waitResult(n);
    checkCount++; if (resData !== 64'hFFFFFFE000000040) $display("[TB] FAIL sign_data: got %h expected ffffffe000000040", resData); else passCount++;
    req = '0;
    doReset();
    fillConst(3, 32'sh80000000, 32'sh80000000);
    req = 4'b1000;
    waitGrant(n);
    waitResult(n);
    checkCount++; if (n != V) $display("[TB] FAIL wrap_valid: got latency %0d expected %0d", n, V); else passCount++;
    checkCount++; if (resData !== 64'd0) $display("[TB] FAIL wrap_data: got %h expected 0", resData); else passCount++;
    checkCount++; if (resId !== 2'd3) $display("[TB] FAIL wrap_id: got %0d expected 3", resId); else passCount++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    doReset();
    fillRandom(2);
    fillRandom(3);
    req = 4'b1100;
    waitGrant(n);
    checkCount++; if (gnt !== 4'b0100) $display("[TB] FAIL abort_first_gnt: got %b expected 0100", gnt); else passCount++;
    waitIdx(10, n);
    req[2] = 1'b0;
    @(negedge clk);
    checkCount++; if (gnt !== '0) $display("[TB] FAIL abort_gnt: got %b expected 0", gnt); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (resValid !== 1'b0) $display("[TB] FAIL abort_valid: got %b expected 0", resValid); else passCount++;
    checkCount++; if (elemIdx !== '0) $display("[TB] FAIL abort_idx: got %0d expected 0", elemIdx); else passCount++;
    @(negedge clk);
    checkCount++; if (gnt !== 4'b1000) $display("[TB] FAIL abort_next_gnt: got %b expected 1000", gnt); else passCount++;
    waitResult(n);
    checkCount++; if (n != V) $display("[TB] FAIL abort_next_latency: got %0d expected %0d", n, V); else passCount++;
    checkCount++; if (resData !== dotRef(3)) $display("[TB] FAIL abort_next_data: got %h expected %h", resData, dotRef(3)); else passCount++;
    checkCount++; if (resId !== 2'd3) $display("[TB] FAIL abort_next_id: got %0d expected 3", resId); else passCount++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    fillRandom(0);
    fillRandom(1);
    req = 4'b0010;
    waitGrant(n);
    checkCount++; if (gnt !== 4'b0010) $display("[TB] FAIL midrst_first_gnt: got %b expected 0010", gnt); else passCount++;
    waitIdx(30, n);
    rst = 1'b1;
    @(negedge clk);
    checkCount++; if (gnt !== '0) $display("[TB] FAIL midrst_gnt: got %b expected 0", gnt); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (resData !== '0) $display("[TB] FAIL midrst_data: got %h expected 0", resData); else passCount++;
    checkCount++; if (resValid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", resValid); else passCount++;
    rst = 1'b0;
    lastModel = N - 1;
    req = 4'b0011;
    waitGrant(n);
    checkCount++; if (gnt !== 4'b0001) $display("[TB] FAIL midrst_regrant: got %b expected 0001", gnt); else passCount++;
    waitResult(n);
    checkCount++; if (resData !== dotRef(0)) $display("[TB] FAIL midrst_data2: got %h expected %h", resData, dotRef(0)); else passCount++;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_random_jobs();
    int n;
    int exp;
    logic [N-1:0] r;
    doReset();
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < N; i++) fillRandom(i);
      r = 4'($urandom_range(1, 15));
      req = r;
      waitGrant(n);
      exp = rrPick(r, lastModel);
      checkCount++; if (gnt !== 4'(1 << exp)) $display("[TB] FAIL rand_gnt job%0d: got %b expected id %0d", j, gnt, exp); else passCount++;
      waitResult(n);
      checkCount++; if (resData !== dotRef(exp)) $display("[TB] FAIL rand_data job%0d: got %h expected %h", j, resData, dotRef(exp)); else passCount++;
      checkCount++; if (resId !== 2'(exp)) $display("[TB] FAIL rand_id job%0d: got %0d expected %0d", j, resId, exp); else passCount++;
      lastModel = exp;
      req = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) fillConst(i, 0, 0);
    test_reset();
    test_single_job();
    test_round_robin();
    test_sign_wrap();
    test_abort();
    test_reset_mid_run();
    test_random_jobs();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
